// File: rtl/pulse_ctrl_pkg.sv
// Shared constants and FSM state encoding for the pulse burst controller.
package pulse_ctrl_pkg;
    localparam int CW_DEF = 16;
    localparam int NW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;
endpackage

// File: rtl/pulse_phase_timer.sv
// Loadable down-counter timing one pulse phase; expire_o flags terminal count.
module pulse_phase_timer
    import pulse_ctrl_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic          expire_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Holds at zero instead of wrapping; the FSM reloads on every phase entry.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_burst_ctrl.sv
// Burst pulse generator: N pulses of W high cycles every P cycles.
// Optional abort input enabled by defining PULSE_BURST_CTRL_ABORT_EN.
//
// state   | meaning
// IDLE    | waiting for start_i with a valid configuration
// HIGH    | pulse_o high, timing W cycles
// LOW     | pulse_o low, timing P-W cycles
// FIN     | one-cycle done_o strobe, then back to IDLE
module pulse_burst_ctrl
    import pulse_ctrl_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int NW = NW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start_i,
    input  logic [CW-1:0] period_i,
    input  logic [CW-1:0] width_i,
    input  logic [NW-1:0] count_i,
    output logic          pulse_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [NW-1:0] remain_o
`ifdef PULSE_BURST_CTRL_ABORT_EN
    ,
    input  logic          abort_i
`endif
);

    state_t        state_q, state_d;
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] width_q, width_d;
    logic [NW-1:0] remain_q, remain_d;
    logic          pulse_q, pulse_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_expire;
    logic          cfg_valid;
    logic [CW-1:0] low_len_m1;

    assign cfg_valid  = (width_i != '0) && (period_i > width_i) && (count_i != '0);
    assign low_len_m1 = period_q - width_q - CW'(1);

    pulse_phase_timer #(.CW(CW)) u_timer (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        width_d  = width_q;
        remain_d = remain_q;
        pulse_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (cfg_valid) begin
                        period_d = period_i;
                        width_d  = width_i;
                        // Acceptance is also the first HIGH entry, so count it here.
                        remain_d = count_i - NW'(1);
                        tmr_load = 1'b1;
                        tmr_val  = width_i - CW'(1);
                        pulse_d  = 1'b1;
                        state_d  = ST_HIGH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_HIGH: begin
                pulse_d = 1'b1;
                if (tmr_expire) begin
                    pulse_d  = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = low_len_m1;
                    state_d  = ST_LOW;
                end
            end
            ST_LOW: begin
                if (tmr_expire) begin
                    if (remain_q != '0) begin
                        remain_d = remain_q - NW'(1);
                        tmr_load = 1'b1;
                        tmr_val  = width_q - CW'(1);
                        pulse_d  = 1'b1;
                        state_d  = ST_HIGH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef PULSE_BURST_CTRL_ABORT_EN
        if (abort_i && (state_q == ST_HIGH || state_q == ST_LOW)) begin
            pulse_d  = 1'b0;
            remain_d = '0;
            done_d   = 1'b1;
            tmr_load = 1'b0;
            state_d  = ST_FIN;
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            period_q <= '0;
            width_q  <= '0;
            remain_q <= '0;
            pulse_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            width_q  <= width_d;
            remain_q <= remain_d;
            pulse_q  <= pulse_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign pulse_o  = pulse_q;
    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign remain_o = remain_q;

endmodule

// File: tb/tb_pulse_burst_ctrl.sv
// Directed bench for pulse_burst_ctrl; outputs compared as {pulse,busy,done,err,remain}.
module tb_pulse_burst_ctrl;

    logic        clk;
    logic        rstn;
    logic        start_i;
    logic [15:0] period_i;
    logic [15:0] width_i;
    logic [7:0]  count_i;
    logic        pulse_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [7:0]  remain_o;
`ifdef PULSE_BURST_CTRL_ABORT_EN
    logic        abort_i;
`endif

    int n_total = 0;
    int n_bad   = 0;

    pulse_burst_ctrl #(.CW(16), .NW(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start_i  (start_i),
        .period_i (period_i),
        .width_i  (width_i),
        .count_i  (count_i),
        .pulse_o  (pulse_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .remain_o (remain_o)
`ifdef PULSE_BURST_CTRL_ABORT_EN
        ,
        .abort_i  (abort_i)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] obs();
        return {pulse_o, busy_o, done_o, err_o, remain_o};
    endfunction

    function automatic logic [11:0] pack(input bit p, input bit b, input bit d,
                                         input bit e, input int r);
        logic [7:0] r8;
        r8 = 8'(r);
        return {p, b, d, e, r8};
    endfunction

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (pulse,busy,done,err,remain)", tag, got, exp);
        end
    endtask

    // Present a configuration with start_i for one edge; returns at the cycle-1 sample point.
    task automatic start_cfg(input int p, input int w, input int n);
        period_i = 16'(p);
        width_i  = 16'(w);
        count_i  = 8'(n);
        start_i  = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
    endtask

    // Checks cycles 1..ncyc of a burst against the ideal train.
    task automatic run_burst(input string tag, input int p, input int w, input int n,
                             input int ncyc, input int dist_c, input bit fin_start);
        int fin;
        logic [11:0] exp;
        fin = p * n + 1;
        for (int c = 1; c <= ncyc; c++) begin
            if (c < fin)
                exp = pack(((c - 1) % p) < w, 1'b1, 1'b0, 1'b0, n - 1 - (c - 1) / p);
            else if (c == fin)
                exp = pack(1'b0, 1'b1, 1'b1, 1'b0, 0);
            else
                exp = pack(1'b0, 1'b0, 1'b0, 1'b0, 0);
            check_eq($sformatf("%s c%0d", tag, c), obs(), exp);
            if (c == dist_c) begin
                period_i = 16'd2;
                width_i  = 16'd1;
                count_i  = 8'd1;
                start_i  = 1'b1;
            end else if (fin_start && c == fin) begin
                period_i = 16'(p);
                width_i  = 16'(w);
                count_i  = 8'(n);
                start_i  = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
        end
        start_i = 1'b0;
    endtask

    task automatic err_case(input string tag, input int p, input int w, input int n);
        start_cfg(p, w, n);
        check_eq({tag, " strobe"}, obs(), pack(1'b0, 1'b0, 1'b0, 1'b1, 0));
        @(negedge clk);
        check_eq({tag, " clear"}, obs(), pack(1'b0, 1'b0, 1'b0, 1'b0, 0));
    endtask

    initial begin
        rstn     = 1'b0;
        start_i  = 1'b0;
        period_i = '0;
        width_i  = '0;
        count_i  = '0;
`ifdef PULSE_BURST_CTRL_ABORT_EN
        abort_i  = 1'b0;
`endif
        #1;
        check_eq("reset_pre_clk", obs(), pack(1'b0, 1'b0, 1'b0, 1'b0, 0));
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_eq("idle_after_reset", obs(), pack(1'b0, 1'b0, 1'b0, 1'b0, 0));

        // Basic two-pulse burst.
        start_cfg(10, 3, 2);
        run_burst("p10w3n2", 10, 3, 2, 23, 0, 1'b0);

        err_case("err_w0", 5, 0, 1);
        err_case("err_p4w4", 4, 4, 1);
        err_case("err_n0", 5, 2, 0);

        // Mid-burst config change and start, plus start during FIN, are all ignored.
        start_cfg(5, 1, 3);
        run_burst("ignore", 5, 1, 3, 18, 4, 1'b1);

        // Reset while the pulse is high must drop it without a clock.
        start_cfg(4, 2, 1);
        #2 rstn = 1'b0;
        #1 check_eq("async_rst_high", obs(), pack(1'b0, 1'b0, 1'b0, 1'b0, 0));
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Reset at cycle 7 of a four-pulse burst, then a fresh burst.
        start_cfg(10, 3, 4);
        run_burst("pre_rst", 10, 3, 4, 6, 0, 1'b0);
        #2 rstn = 1'b0;
        #1 check_eq("async_rst_c7", obs(), pack(1'b0, 1'b0, 1'b0, 1'b0, 0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("in_rst %0d", i), obs(), pack(1'b0, 1'b0, 1'b0, 1'b0, 0));
        end
        rstn = 1'b1;
        @(negedge clk);
        check_eq("post_rst_idle", obs(), pack(1'b0, 1'b0, 1'b0, 1'b0, 0));
        start_cfg(3, 1, 1);
        run_burst("post_rst", 3, 1, 1, 5, 0, 1'b0);

`ifdef PULSE_BURST_CTRL_ABORT_EN
        start_cfg(8, 2, 5);
        check_eq("abort c1", obs(), pack(1'b1, 1'b1, 1'b0, 1'b0, 4));
        @(negedge clk);
        check_eq("abort c2", obs(), pack(1'b1, 1'b1, 1'b0, 1'b0, 4));
        @(negedge clk);
        check_eq("abort c3", obs(), pack(1'b0, 1'b1, 1'b0, 1'b0, 4));
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check_eq("abort fin", obs(), pack(1'b0, 1'b1, 1'b1, 1'b0, 0));
        @(negedge clk);
        check_eq("abort idle", obs(), pack(1'b0, 1'b0, 1'b0, 1'b0, 0));
        @(negedge clk);
`endif

        // Densest train: 255 pulses at P=2.
        start_cfg(2, 1, 255);
        run_burst("n255", 2, 1, 255, 513, 0, 1'b0);

        // Counter extremes: P=2^16-1, W=2^16-2.
        start_cfg(65535, 65534, 1);
        run_burst("max", 65535, 65534, 1, 65537, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
